seq_div: RTL and testbench

Sequential restoring divider: the inverse of the team's bit-serial shift-and-add multiplier (`seq_mul`). It divides a 16-bit dividend by an 8-bit divisor and develops one quotient bit per clock, MSB first. Each bit is also streamed on a serial output so downstream logic can consume the quotient the same way `seq_mul` consumes its multiplier. A `seq_mul` product fed back through `seq_div` with the same operand recovers the original factor.

---
 rtl/seq_arith_pkg.sv | 8 +
 rtl/seq_div_step.sv | 20 ++
 rtl/seq_div.sv | 103 ++++++++++
 tb/tb_seq_div.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/seq_arith_pkg.sv
// Widths and state encoding shared by the bit-serial arithmetic units (seq_mul, seq_div).
package seq_arith_pkg;
    localparam int DW = 16;
    localparam int VW = 8;
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} div_state_t;
endpackage

// File: rtl/seq_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
import seq_arith_pkg::*;

module div_step (
    input  logic [VW:0]   r,
    input  logic          d_bit,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   r_next,
    output logic          q
);
    logic [VW:0] rs;
    logic [VW:0] dv;

    always_comb begin
        rs     = {r[VW-1:0], d_bit};
        dv     = {1'b0, divisor};
        q      = (rs >= dv);
        r_next = q ? (rs - dv) : rs;
    end
endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one quotient bit per clock.
import seq_arith_pkg::*;

module seq_div (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          q_bit,
    output logic          q_valid,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          done,
    output logic          div_by_zero
);
    div_state_t    state;
    logic [CW-1:0] cnt;
    logic [VW:0]   rem_r;
    logic [DW-1:0] dreg;
    logic [VW-1:0] dvs;

    logic [VW:0]   step_r_in;
    logic [VW:0]   step_r_next;
    logic          step_q;

    // The first iteration runs on the LOAD->RUN edge from a zero remainder, so the
    // registered q_bit/q_valid cover exactly the DW RUN cycles.
    assign step_r_in = (state == LOAD) ? '0 : rem_r;

    div_step u_step (
        .r       (step_r_in),
        .d_bit   (dreg[DW-1]),
        .divisor (dvs),
        .r_next  (step_r_next),
        .q       (step_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rem_r       <= '0;
            dreg        <= '0;
            dvs         <= '0;
            busy        <= 1'b0;
            q_bit       <= 1'b0;
            q_valid     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= LOAD;
                        dreg        <= dividend;
                        dvs         <= divisor;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        div_by_zero <= 1'b0;
                    end
                end
                LOAD: begin
                    if (dvs == '0) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        quotient    <= '1;
                        remainder   <= dreg[VW-1:0];
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                    end else begin
                        state   <= RUN;
                        cnt     <= CW'(DW - 1);
                        rem_r   <= step_r_next;
                        dreg    <= {dreg[DW-2:0], step_q};
                        q_bit   <= step_q;
                        q_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        q_bit     <= 1'b0;
                        q_valid   <= 1'b0;
                        quotient  <= dreg;
                        remainder <= rem_r[VW-1:0];
                        done      <= 1'b1;
                    end else begin
                        cnt   <= cnt - 1'b1;
                        rem_r <= step_r_next;
                        dreg  <= {dreg[DW-2:0], step_q};
                        q_bit <= step_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_div.sv
// Directed and randomized checks of seq_div against hand-computed results and / and %.
module tb_seq_div;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        busy, q_bit, q_valid, done, div_by_zero;
    logic [15:0] quotient;
    logic [7:0]  remainder;

    int passed = 0;
    int total  = 0;

    int          edges;
    int          nvalid;
    logic [15:0] qstream;

    seq_div dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .q_bit       (q_bit),
        .q_valid     (q_valid),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Drives start for one edge (E0) and returns at the following negedge.
    task automatic launch(input logic [15:0] dd, input logic [7:0] dv);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges after E0 until done, collecting the serial quotient.
    task automatic wait_done();
        edges   = 0;
        nvalid  = 0;
        qstream = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (q_valid) begin
                qstream = {qstream[14:0], q_bit};
                nvalid++;
            end
            if (done) break;
        end
        if (!done) check("timeout", 32'(done), 32'd1);
    endtask

    task automatic run_div(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                           input logic [15:0] eq, input logic [7:0] er, input logic ez,
                           input int elat);
        launch(dd, dv);
        wait_done();
        check({tag, ".quot"}, 32'(quotient), 32'(eq));
        check({tag, ".rem"},  32'(remainder), 32'(er));
        check({tag, ".dbz"},  32'(div_by_zero), 32'(ez));
        if (elat > 0) check({tag, ".lat"}, 32'(edges + 1), 32'(elat));
    endtask

    initial begin
        // Reset state
        #2;
        check("rst.busy", 32'(busy), 0);
        check("rst.done", 32'(done), 0);
        check("rst.qv",   32'(q_valid), 0);
        check("rst.quot", 32'(quotient), 0);
        @(negedge clk);
        reset = 1'b1;

        // 592 / 16: inverse of 37*16, serial stream and 18-edge latency
        run_div("d592", 16'd592, 8'd16, 16'd37, 8'd0, 1'b0, 18);
        check("d592.stream", 32'(qstream), 32'h0025);
        check("d592.nvalid", nvalid, 16);
        check("d592.busy", 32'(busy), 0);

        run_div("d1000", 16'd1000, 8'd7,   16'd142,   8'd6,   1'b0, 18);
        check("d1000.stream", 32'(qstream), 32'd142);
        run_div("dmax1", 16'd65535, 8'd1,  16'd65535, 8'd0,   1'b0, 18);
        run_div("dmax255", 16'd65535, 8'd255, 16'd257, 8'd0,  1'b0, 18);
        run_div("d200", 16'd200, 8'd255,   16'd0,     8'd200, 1'b0, 18);

        // Divide by zero: done two edges after start, no q_valid pulses
        run_div("dz", 16'd1234, 8'd0, 16'hFFFF, 8'hD2, 1'b1, 2);
        check("dz.nvalid", nvalid, 0);
        check("dz.done", 32'(done), 1);

        // Start pulsed mid-RUN is ignored
        launch(16'd1000, 8'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        dividend = 16'd50;
        divisor  = 8'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        check("ign.quot", 32'(quotient), 142);
        check("ign.rem",  32'(remainder), 6);

        // Start held in DONE restarts; done drops right away
        launch(16'd50, 8'd3);
        check("b2b.done_drop", 32'(done), 0);
        check("b2b.busy", 32'(busy), 1);
        wait_done();
        check("b2b.lat",  edges + 1, 18);
        check("b2b.quot", 32'(quotient), 16);
        check("b2b.rem",  32'(remainder), 2);

        // Asynchronous reset at RUN cycle 8
        launch(16'd592, 8'd16);
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("mrst.busy", 32'(busy), 0);
        check("mrst.qv",   32'(q_valid), 0);
        check("mrst.qbit", 32'(q_bit), 0);
        check("mrst.done", 32'(done), 0);
        check("mrst.quot", 32'(quotient), 0);
        check("mrst.rem",  32'(remainder), 0);
        check("mrst.dbz",  32'(div_by_zero), 0);
        @(negedge clk);
        reset = 1'b1;
        run_div("post", 16'd592, 8'd16, 16'd37, 8'd0, 1'b0, 18);
        check("post.stream", 32'(qstream), 32'h0025);

        // Randomized operands against / and %
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] rd;
            logic [7:0]  rv;
            rd = 16'($urandom);
            rv = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            if (rv == 0)
                run_div("rnd", rd, rv, 16'hFFFF, rd[7:0], 1'b1, 2);
            else
                run_div("rnd", rd, rv, rd / 16'(rv), 8'(rd % 16'(rv)), 1'b0, 18);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
